// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: serialises fetch reads, exec reads and exec writes onto
// the single-ported PDP-8 main memory.
//
// Priority is exec_wr > exec_rd > ifu_rd. A requester whose ack was high in
// the previous cycle is skipped, so a level request is never granted twice.
// Writes finish in one cycle. Reads take three cycles: strobe, wait, capture.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch starvation
// guard. After STARVE_LIMIT exec grants made while fetch waits, the next grant
// goes to fetch.
module pdp8_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_ack,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_ack,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_CAPT = 2'd2} state_t;

  state_t state, state_next;
  logic   elig_wr, elig_erd, elig_ifu;
  logic   force_ifu;
  logic   grant_wr, grant_erd, grant_ifu;
  logic   winner_exec;

  // Lockout: an ack that was high last cycle blocks that requester now.
  assign elig_wr  = exec_wr_req && !exec_wr_ack;
  assign elig_erd = exec_rd_req && !exec_rd_ack;
  assign elig_ifu = ifu_rd_req  && !ifu_rd_ack;

  assign busy = (state != IDLE);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt;

  assign force_ifu = elig_ifu && (starve_cnt >= LIMIT);

  // Count exec grants taken while fetch waits; saturate at 7; clear when fetch is served or idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= 3'd0;
    end else if (!ifu_rd_req || grant_ifu) begin
      starve_cnt <= 3'd0;
    end else if ((grant_wr || grant_erd) && elig_ifu && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign force_ifu = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant decode; grants are only made from IDLE.
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_erd  = 1'b0;
    grant_ifu  = 1'b0;
    case (state)
      IDLE: begin
        if (force_ifu) begin
          grant_ifu  = 1'b1;
          state_next = RD_WAIT;
        end else if (elig_wr) begin
          grant_wr   = 1'b1;
        end else if (elig_erd) begin
          grant_erd  = 1'b1;
          state_next = RD_WAIT;
        end else if (elig_ifu) begin
          grant_ifu  = 1'b1;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: state_next = RD_CAPT;
      RD_CAPT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered memory commands, acks and read data capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      exec_wr_ack  <= 1'b0;
      exec_rd_ack  <= 1'b0;
      ifu_rd_ack   <= 1'b0;
      exec_rd_data <= '0;
      ifu_rd_data  <= '0;
      winner_exec  <= 1'b0;
    end else begin
      mem_rd_en   <= grant_erd || grant_ifu;
      mem_wr_en   <= grant_wr;
      exec_wr_ack <= grant_wr;
      exec_rd_ack <= 1'b0;
      ifu_rd_ack  <= 1'b0;
      if (grant_wr) begin
        mem_addr  <= exec_wr_addr;
        mem_wdata <= exec_wr_data;
      end else if (grant_erd) begin
        mem_addr    <= exec_rd_addr;
        winner_exec <= 1'b1;
      end else if (grant_ifu) begin
        mem_addr    <= ifu_rd_addr;
        winner_exec <= 1'b0;
      end
      if (state == RD_CAPT) begin
        if (winner_exec) begin
          exec_rd_data <= mem_rdata;
          exec_rd_ack  <= 1'b1;
        end else begin
          ifu_rd_data <= mem_rdata;
          ifu_rd_ack  <= 1'b1;
        end
      end
    end
  end

endmodule
